// File: rtl/rcpu_mem_responder.sv
// Memory-side responder for the RCPU bus: word RAM plus an I/O page holding an
// output FIFO (ready/valid drain) and a down-counting timer with a sticky irq.
module rcpu_mem_responder #(
  parameter int M  = 16,
  parameter int AW = 8,
  parameter int FD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] memAddr,
  input  logic [M-1:0] memWrite,
  input  logic         memWE,
  output logic [M-1:0] memRead,
  output logic [M-1:0] outData,
  output logic         outValid,
  input  logic         outReady,
  output logic         timerIrq
);

  localparam int PW = $clog2(FD);

  localparam logic [M-1:0] ADDR_OUT    = M'(16'hFFF0);
  localparam logic [M-1:0] ADDR_STATUS = M'(16'hFFF1);
  localparam logic [M-1:0] ADDR_TCOUNT = M'(16'hFFF2);
  localparam logic [M-1:0] ADDR_TCTRL  = M'(16'hFFF3);
  localparam logic [PW:0]  CNT_FULL    = (PW+1)'(FD);

  // Storage without reset: RAM survives reset, FIFO slots are don't-care when empty
  logic [M-1:0] mem_q [2**AW];
  logic [M-1:0] buf_q [FD];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic          en_q, en_d;
  logic [M-1:0]  count_q, count_d;
  logic [M-1:0]  reload_q, reload_d;

  logic is_ram;
  logic wr_out, wr_status, wr_tcount, wr_tctrl;
  logic empty, full, pop, push, ovf_set, expire;

  assign is_ram    = (memAddr[M-1:AW] == '0);
  assign wr_out    = memWE && (memAddr == ADDR_OUT);
  assign wr_status = memWE && (memAddr == ADDR_STATUS);
  assign wr_tcount = memWE && (memAddr == ADDR_TCOUNT);
  assign wr_tctrl  = memWE && (memAddr == ADDR_TCTRL);

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign pop     = !empty && outReady;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign push    = wr_out && (!full || pop);
  assign ovf_set = wr_out && full && !pop;
  assign expire  = en_q && !wr_tcount && (count_q == '0);

  always_comb begin
    memRead = '0;
    if (is_ram) begin
      memRead = mem_q[memAddr[AW-1:0]];
    end else begin
      case (memAddr)
        ADDR_STATUS: memRead = {{(M-4){1'b0}}, ovf_q, irq_q, full, empty};
        ADDR_TCOUNT: memRead = count_q;
        ADDR_TCTRL:  memRead = {{(M-1){1'b0}}, en_q};
        default:     memRead = '0;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end

    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (wr_status && memWrite[3]) begin
      ovf_d = 1'b0;
    end

    irq_d = irq_q;
    if (expire) begin
      irq_d = 1'b1;
    end else if (wr_status && memWrite[2]) begin
      irq_d = 1'b0;
    end

    en_d = wr_tctrl ? memWrite[0] : en_q;

    reload_d = reload_q;
    count_d  = count_q;
    if (wr_tcount) begin
      reload_d = memWrite;
      count_d  = memWrite;
    end else if (expire) begin
      count_d = reload_q;
    end else if (en_q) begin
      count_d = count_q - M'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      en_q     <= 1'b0;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      en_q     <= en_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWE && is_ram) begin
      mem_q[memAddr[AW-1:0]] <= memWrite;
    end
    if (push) begin
      buf_q[wr_ptr_q] <= memWrite;
    end
  end

  assign outData  = buf_q[rd_ptr_q];
  assign outValid = !empty;
  assign timerIrq = irq_q;

endmodule
